step_seq: RTL and testbench
===========================

# step_seq

Parametrised stepping sequencer, the next generation of the start/done accumulate-to-target `example` core. On `start` it loads a start value, then adds or subtracts a fixed offset once per cycle until `variable` reaches `target`. It clamps any overshoot to `target` and reports completion, error or abort with a 3-bit state. It sits behind the same test-fixture style drivers: `start` pulses in, a `done` level comes out, and `state`/`variable` are exposed for monitoring and dumps.

## Interface
- `WIDTH`, default 8: width of `init`, `target`, `variable` and `steps`.
- `OFFSET_W`, default 2: width of `offset`; must be ≤ `WIDTH`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low. Low forces all state and outputs to reset values immediately.
- `start` in 1: request; sampled only in IDLE.
- `abort` in 1: cancel; highest priority in every non-IDLE state.
- `mode` in 1: 0 = count up, 1 = count down.
- `offset` in `OFFSET_W`: step size, zero-extended to `WIDTH`.
- `init` in `WIDTH`: start value.
- `target` in `WIDTH`: end value.
- `done` out 1: high while in DONE.
- `err` out 1: high while in ERR.
- `busy` out 1: high in LOAD and RUN.
- `overshoot` out 1: last run clamped, i.e. the final step passed `target`.
- `state` out 3: current FSM state encoding.
- `variable` out `WIDTH`: running value.
- `steps` out `WIDTH`: RUN steps taken in the current/last run; saturates at all-ones.

## Operation
- State encodings: IDLE=0, LOAD=1, RUN=2, DONE=3, ERR=4. Codes 5–7 are unreachable and recover to IDLE on the next edge.
- Reset values: `state`=IDLE, `variable`=0, `steps`=0, and `done`, `err`, `busy`, `overshoot` all 0.
- **IDLE:**
  - `start`=1 and `abort`=0 → LOAD.
  - Otherwise stay. `variable`, `steps` and `overshoot` hold their last run's values.
- **LOAD:**
  - Captures `mode`, `offset` and `target` into internal registers; input changes after this edge are ignored.
  - Sets `variable`←`init`, `steps`←0, `overshoot`←0.
  - Next state, first match wins:
    - `init`==`target` → DONE.
    - `offset`==0 → ERR.
    - up with `init`>`target`, or down with `init`<`target` → ERR.
    - else → RUN.
- **RUN, up:** sum computed at `WIDTH`+1 bits.
  - sum ≥ target: `variable`←target, `overshoot`←(sum≠target), → DONE.
  - Else `variable`←sum.
- **RUN, down:** difference computed at `WIDTH`+1 bits with borrow.
  - borrow set or diff ≤ target: `variable`←target, `overshoot`←(diff≠target or borrow), → DONE.
  - Else `variable`←diff.
- **RUN, both modes:** `steps` increments every RUN cycle, saturating.
- **DONE / ERR:** hold the result. Leave to IDLE on the first edge where `start`=0. A `start` held high never retriggers.
- **abort:** in LOAD, RUN, DONE or ERR → IDLE next edge. `variable` and `steps` freeze at their current values; `done` is never asserted for the aborted run. `start`=`abort`=1 in IDLE → stay IDLE.
- Wrap-around never occurs: the carry/borrow bit forces the clamp.

## Timing
- `start` sampled high at edge N in IDLE:
  - LOAD from N; RUN from N+1.
  - First step lands at N+2; step k lands at edge N+1+k.
- Run length: the number of RUN cycles is ceil(|target−init| / offset). `done` rises after edge N+1+that count and stays high until the edge after `start` falls.
- Immediate cases: `init`==`target` gives `done` after edge N+1 with `steps`=0. An ERR condition gives `err` after edge N+1.
- Output timing: all outputs are registered or decoded from registered state; no input-to-output combinational path.
- Reset mid-run: outputs reach reset values asynchronously. The first start is accepted on the first edge after `reset` deasserts.

## Test plan
- **Basic up run:** WIDTH=8, up, init 0, offset 2, target 120, start held 2 cycles.
  - Required: state 0→1→2, then 60 RUN cycles.
  - Then `variable`=120, `steps`=60, `overshoot`=0, `done`=1 after edge N+61.
  - Returns to IDLE after `start` drops.
- **Clamp:**
  - up, init 0, offset 3, target 10 → 3, 6, 9, then clamp to 10; `steps`=4, `overshoot`=1.
  - up, init 250, offset 3, target 255 → 253, then clamp 255 via carry; `steps`=2, `overshoot`=1, no wrap to 0.
- **Down:** init 200, offset 3, target 5 → 65 steps, `variable`=5, `overshoot`=0. Then init 4, offset 3, target 0 → 1, then borrow clamp to 0, `overshoot`=1.
- **Errors:**
  - offset 0, init 0, target 7 → state 4, `err`=1 after edge N+1.
  - up with init 9, target 3 → ERR.
  - init==target=42 → DONE with `steps`=0.
- **Abort and reset:**
  - `abort` at step 10 of the basic run → IDLE next edge, `variable`=20, `done` never high.
  - `reset` low mid-run → all outputs 0 without a clock edge; a fresh start after release completes normally.

Source files
------------

// File: rtl/step_seq.sv
// Stepping sequencer: loads init on start, then steps variable toward target by a fixed
// offset each cycle, clamping overshoot. Handshake: start is a request sampled only in IDLE; done/err are levels held until start is low.
module step_seq #(
  parameter int WIDTH    = 8,
  parameter int OFFSET_W = 2
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                mode_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [WIDTH-1:0]    init_i,
  input  logic [WIDTH-1:0]    target_i,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o,
  output logic                overshoot_o,
  output logic [2:0]          state_o,
  output logic [WIDTH-1:0]    variable_o,
  output logic [WIDTH-1:0]    steps_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] var_q, var_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             ovs_q, ovs_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             done_q, err_q, busy_q;

  logic [WIDTH-1:0] off_ext;
  logic [WIDTH:0]   sum, diff, tgt_x;

  // The extra top bit is the carry (up) or borrow (down); either one forces the clamp.
  assign off_ext = WIDTH'(offset_i);
  assign sum     = {1'b0, var_q} + {1'b0, off_q};
  assign diff    = {1'b0, var_q} - {1'b0, off_q};
  assign tgt_x   = {1'b0, tgt_q};

  always_comb begin
    state_d = state_q;
    var_d   = var_q;
    steps_d = steps_q;
    ovs_d   = ovs_q;
    mode_d  = mode_q;
    off_d   = off_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) state_d = LOAD;
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          mode_d  = mode_i;
          off_d   = off_ext;
          tgt_d   = target_i;
          var_d   = init_i;
          steps_d = '0;
          ovs_d   = 1'b0;
          if (init_i == target_i)                       state_d = DONE;
          else if (offset_i == '0)                      state_d = ERR;
          else if ((!mode_i && (init_i > target_i)) ||
                   ( mode_i && (init_i < target_i)))    state_d = ERR;
          else                                          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          steps_d = (&steps_q) ? steps_q : steps_q + 1'b1;
          if (!mode_q) begin
            if (sum >= tgt_x) begin
              var_d   = tgt_q;
              ovs_d   = (sum != tgt_x);
              state_d = DONE;
            end else begin
              var_d = sum[WIDTH-1:0];
            end
          end else begin
            if (diff[WIDTH] || (diff <= tgt_x)) begin
              var_d   = tgt_q;
              ovs_d   = diff[WIDTH] || (diff != tgt_x);
              state_d = DONE;
            end else begin
              var_d = diff[WIDTH-1:0];
            end
          end
        end
      end
      DONE, ERR: begin
        if (abort_i || !start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      var_q   <= '0;
      steps_q <= '0;
      ovs_q   <= 1'b0;
      mode_q  <= 1'b0;
      off_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      var_q   <= var_d;
      steps_q <= steps_d;
      ovs_q   <= ovs_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      tgt_q   <= tgt_d;
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERR);
      busy_q  <= (state_d == LOAD) || (state_d == RUN);
    end
  end

  assign state_o     = state_q;
  assign variable_o  = var_q;
  assign steps_o     = steps_q;
  assign overshoot_o = ovs_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_step_seq.sv
// Bench for step_seq: directed and random runs checked against a closed-form model
// (run length = ceil(|target-init|/offset)) plus abort, start-hold and reset scenarios.
`timescale 1ns/1ps
module tb_step_seq;

  logic       clk_i, reset_ni, start_i, abort_i, mode_i;
  logic [1:0] offset_i;
  logic [7:0] init_i, target_i;
  logic       done_o, err_o, busy_o, overshoot_o;
  logic [2:0] state_o;
  logic [7:0] variable_o, steps_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] last_var   = 8'd0;
  logic [7:0] last_steps = 8'd0;
  logic       last_ovs   = 1'b0;

  wire [22:0] obs = {state_o, done_o, err_o, busy_o, overshoot_o, variable_o, steps_o};

  step_seq #(.WIDTH(8), .OFFSET_W(2)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .offset_i(offset_i), .init_i(init_i), .target_i(target_i),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .overshoot_o(overshoot_o),
    .state_o(state_o), .variable_o(variable_o), .steps_o(steps_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Expected observable vector from state code and data values.
  function automatic logic [22:0] pk(input logic [2:0] s, input logic o,
                                     input logic [7:0] v, input logic [7:0] st);
    return {s, (s == 3'd3), (s == 3'd4), (s == 3'd1) || (s == 3'd2), o, v, st};
  endfunction

  // Closed-form outcome of one run.
  task automatic model(input int vi, input int vt, input int vo, input bit vm,
                       output bit is_err, output int n, output bit ovs);
    int d;
    is_err = 1'b0; n = 0; ovs = 1'b0;
    d = vm ? (vi - vt) : (vt - vi);
    if (vi == vt)      n = 0;
    else if (vo == 0)  is_err = 1'b1;
    else if (d < 0)    is_err = 1'b1;
    else begin
      n   = (d + vo - 1) / vo;
      ovs = (d % vo) != 0;
    end
  endtask

  task automatic run_case(input string nm, input logic [7:0] vi, input logic [7:0] vt,
                          input logic [1:0] vo, input logic vm);
    bit is_err; int n; bit ovs; logic [22:0] exp; logic [7:0] v;
    model(int'(vi), int'(vt), int'(vo), vm, is_err, n, ovs);
    @(posedge clk_i); #1;
    init_i = vi; target_i = vt; offset_i = vo; mode_i = vm; start_i = 1'b1;
    @(posedge clk_i); #1;
    exp = pk(3'd1, last_ovs, last_var, last_steps);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL %s load: got %h want %h", nm, obs, exp); end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    init_i = 8'($urandom); target_i = 8'($urandom);
    offset_i = 2'($urandom); mode_i = 1'($urandom);
    if (is_err)      exp = pk(3'd4, 1'b0, vi, 8'd0);
    else if (n == 0) exp = pk(3'd3, 1'b0, vi, 8'd0);
    else             exp = pk(3'd2, 1'b0, vi, 8'd0);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL %s first: got %h want %h", nm, obs, exp); end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk_i); #1;
      v = vm ? 8'(int'(vi) - k * int'(vo)) : 8'(int'(vi) + k * int'(vo));
      exp = (k == n) ? pk(3'd3, ovs, vt, 8'(k)) : pk(3'd2, 1'b0, v, 8'(k));
      total++;
      if (obs !== exp) begin bad++; $display("FAIL %s step%0d: got %h want %h", nm, k, obs, exp); end
    end
    last_ovs   = (n > 0) && ovs;
    last_var   = (n > 0) ? vt : vi;
    last_steps = 8'(n);
    @(posedge clk_i); #1;
    exp = pk(3'd0, last_ovs, last_var, last_steps);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL %s idle: got %h want %h", nm, obs, exp); end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; start_i = 1'b1; abort_i = 1'b0; mode_i = 1'b0;
    offset_i = 2'd1; init_i = 8'd5; target_i = 8'd9;
    #2;
    total++;
    if (obs !== 23'd0) begin bad++; $display("FAIL reset_t0: got %h want 0", obs); end
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (obs !== 23'd0) begin bad++; $display("FAIL reset_held: got %h want 0", obs); end
    start_i = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_directed();
    run_case("basic_up", 8'd0, 8'd120, 2'd2, 1'b0);
    run_case("clamp_up", 8'd0, 8'd10, 2'd3, 1'b0);
    run_case("carry_clamp", 8'd250, 8'd255, 2'd3, 1'b0);
    run_case("down", 8'd200, 8'd5, 2'd3, 1'b1);
    run_case("borrow_clamp", 8'd4, 8'd0, 2'd3, 1'b1);
  endtask

  task automatic test_errors();
    run_case("err_offset0", 8'd0, 8'd7, 2'd0, 1'b0);
    run_case("err_dir_up", 8'd9, 8'd3, 2'd1, 1'b0);
    run_case("err_dir_down", 8'd3, 8'd9, 2'd2, 1'b1);
    run_case("equal", 8'd42, 8'd42, 2'd1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] vi, vt; logic vm;
    for (int i = 0; i < 16; i++) begin
      vi = 8'($urandom); vt = 8'($urandom);
      vm = (($urandom_range(0, 3)) == 0) ? 1'($urandom) : (vt < vi);
      run_case("random", vi, vt, 2'($urandom_range(0, 3)), vm);
    end
  endtask

  task automatic test_abort();
    logic [22:0] exp; bit saw_done = 1'b0;
    @(posedge clk_i); #1;
    init_i = 8'd0; target_i = 8'd120; offset_i = 2'd2; mode_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      saw_done |= done_o;
    end
    exp = pk(3'd2, 1'b0, 8'd20, 8'd10);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_step10: got %h want %h", obs, exp); end
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    saw_done |= done_o;
    exp = pk(3'd0, 1'b0, 8'd20, 8'd10);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_idle: got %h want %h", obs, exp); end
    abort_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      saw_done |= done_o;
    end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_hold: got %h want %h", obs, exp); end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %0b want 0", saw_done); end
    last_var = 8'd20; last_steps = 8'd10; last_ovs = 1'b0;
  endtask

  task automatic test_start_hold();
    logic [22:0] exp;
    @(posedge clk_i); #1;
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    exp = pk(3'd0, last_ovs, last_var, last_steps);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL start_abort_idle: got %h want %h", obs, exp); end
    abort_i = 1'b0; init_i = 8'd77; target_i = 8'd77; offset_i = 2'd1;
    repeat (4) @(posedge clk_i);
    #1;
    exp = pk(3'd3, 1'b0, 8'd77, 8'd0);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL hold_done: got %h want %h", obs, exp); end
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    exp = pk(3'd0, 1'b0, 8'd77, 8'd0);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL hold_release: got %h want %h", obs, exp); end
    last_var = 8'd77; last_steps = 8'd0; last_ovs = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk_i); #1;
    init_i = 8'd0; target_i = 8'd120; offset_i = 2'd2; mode_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #3;
    reset_ni = 1'b0;
    #1;
    total++;
    if (obs !== 23'd0) begin bad++; $display("FAIL async_reset: got %h want 0", obs); end
    #2;
    reset_ni = 1'b1;
    last_var = 8'd0; last_steps = 8'd0; last_ovs = 1'b0;
    run_case("after_reset", 8'd0, 8'd120, 2'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_abort();
    test_start_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
